ip_mac_sequencer: RTL and testbench



---
 rtl/ip_mac_sequencer.sv | 138 +++++++++++++
 tb/tb_ip_mac_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ip_mac_sequencer.sv
// ip_mac_sequencer: shared-MAC one-vs-all scorer with signed argmax; define IPSEQ_SAT_EN for saturating accumulate.
module ip_mac_sequencer #(
    parameter int NFEAT  = 41,
    parameter int NCLASS = 10,
    parameter int W      = 32,
    parameter int XAW    = 6,
    parameter int TAW    = 9,
    parameter int CW     = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic [XAW-1:0] x_addr,
    input  logic [W-1:0]   x_data,
    output logic [TAW-1:0] th_addr,
    input  logic [W-1:0]   th_data,
    output logic           hp_valid,
    output logic [W-1:0]   hp_value,
    output logic [CW-1:0]  hp_class,
    output logic           done,
    output logic [CW-1:0]  best_class,
    output logic [W-1:0]   best_value
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t         state_q, state_d;
    logic [XAW-1:0] k_q, k_d, pk_q, pk_d;
    logic [CW-1:0]  c_q, c_d, pc_q, pc_d;
    logic [TAW-1:0] ta_q, ta_d;
    logic           v_q, v_d;
    logic [W-1:0]   acc_q, acc_d;
    logic           hp_valid_q, hp_valid_d, done_q, done_d;
    logic [W-1:0]   hp_value_q, hp_value_d, best_value_q, best_value_d;
    logic [CW-1:0]  hp_class_q, hp_class_d, best_class_q, best_class_d;
    logic [W-1:0]   prod, term, acc_add, sum;
    logic           last;
    assign busy       = state_q != IDLE;
    assign x_addr     = k_q;
    assign th_addr    = ta_q;
    assign hp_valid   = hp_valid_q;
    assign hp_value   = hp_value_q;
    assign hp_class   = hp_class_q;
    assign done       = done_q;
    assign best_class = best_class_q;
    assign best_value = best_value_q;
    assign prod       = x_data * th_data;
    assign last       = (k_q == XAW'(NFEAT - 1)) && (c_q == CW'(NCLASS - 1));
`ifdef IPSEQ_SAT_EN
    logic [W-1:0] wsum;
    assign wsum    = acc_q + term;
    // Overflow only when both operands share a sign the result lacks.
    assign acc_add = (acc_q[W-1] == term[W-1]) && (wsum[W-1] != acc_q[W-1])
                   ? {acc_q[W-1], {(W-1){~acc_q[W-1]}}} : wsum;
`else
    assign acc_add = acc_q + term;
`endif
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        c_d          = c_q;
        ta_d         = ta_q;
        v_d          = state_q == RUN;
        pk_d         = k_q;
        pc_d         = c_q;
        acc_d        = acc_q;
        hp_valid_d   = 1'b0;
        done_d       = 1'b0;
        hp_value_d   = hp_value_q;
        hp_class_d   = hp_class_q;
        best_value_d = best_value_q;
        best_class_d = best_class_q;
        term         = pk_q == '0 ? th_data : pk_q == XAW'(1) ? '0 : prod;
        sum          = pk_q == '0 ? term : acc_add;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                k_d     = '0;
                c_d     = '0;
                ta_d    = '0;
            end
            RUN: if (last) begin
                state_d = DRAIN;
            end else begin
                k_d  = k_q == XAW'(NFEAT - 1) ? '0 : k_q + 1'b1;
                c_d  = k_q == XAW'(NFEAT - 1) ? c_q + 1'b1 : c_q;
                ta_d = ta_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // v_q marks data returning for the address issued two edges ago.
        if (v_q) begin
            acc_d = sum;
            if (pk_q == XAW'(NFEAT - 1)) begin
                hp_valid_d = 1'b1;
                hp_value_d = sum;
                hp_class_d = pc_q;
                done_d     = pc_q == CW'(NCLASS - 1);
                if (pc_q == '0 || $signed(sum) > $signed(best_value_q)) begin
                    best_value_d = sum;
                    best_class_d = pc_q;
                end
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            c_q          <= '0;
            ta_q         <= '0;
            v_q          <= 1'b0;
            pk_q         <= '0;
            pc_q         <= '0;
            acc_q        <= '0;
            hp_valid_q   <= 1'b0;
            done_q       <= 1'b0;
            hp_value_q   <= '0;
            hp_class_q   <= '0;
            best_value_q <= '0;
            best_class_q <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            c_q          <= c_d;
            ta_q         <= ta_d;
            v_q          <= v_d;
            pk_q         <= pk_d;
            pc_q         <= pc_d;
            acc_q        <= acc_d;
            hp_valid_q   <= hp_valid_d;
            done_q       <= done_d;
            hp_value_q   <= hp_value_d;
            hp_class_q   <= hp_class_d;
            best_value_q <= best_value_d;
            best_class_q <= best_class_d;
        end
    end
endmodule

// File: tb/tb_ip_mac_sequencer.sv
// tb_ip_mac_sequencer: directed vectors with hand-computed scores against ip_mac_sequencer.
module tb_ip_mac_sequencer;
    logic        clk = 0, reset = 1, start = 0;
    logic        busy, hp_valid, done;
    logic [5:0]  x_addr;
    logic [8:0]  th_addr;
    logic [31:0] x_data, th_data, hp_value, best_value;
    logic [3:0]  hp_class, best_class;
    logic [31:0] x_mem [64];
    logic [31:0] th_mem[512];
    logic [31:0] hv[$];
    int          hc[$];
    int          checks = 0, failures = 0;

    ip_mac_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .x_addr(x_addr), .x_data(x_data), .th_addr(th_addr), .th_data(th_data),
        .hp_valid(hp_valid), .hp_value(hp_value), .hp_class(hp_class),
        .done(done), .best_class(best_class), .best_value(best_value)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        x_data  <= x_mem[x_addr];
        th_data <= th_mem[th_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [31:0] xv, input logic [31:0] tv);
        for (int i = 0; i < 64; i++) x_mem[i] = xv;
        for (int i = 0; i < 512; i++) th_mem[i] = tv;
    endtask

    task automatic run(input bit extra);
        int n;
        hv.delete();
        hc.delete();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n = 0;
        while (n <= 1000) begin
            if (n == 0) begin
                chk("busy_rise", busy, 1);
                chk("x_addr0", x_addr, 0);
                chk("th_addr0", th_addr, 0);
            end
            if (n == 2) begin
                chk("x_addr2", x_addr, 2);
                chk("th_addr2", th_addr, 2);
            end
            if (n == 409) begin
                chk("x_addr409", x_addr, 40);
                chk("th_addr409", th_addr, 409);
            end
            start = extra && (n == 50);
            if (hp_valid) begin
                hv.push_back(hp_value);
                hc.push_back(int'(hp_class));
            end
            if (done) break;
            @(negedge clk);
            n++;
        end
        chk("done_cycle", n, 411);
        chk("busy_at_done", busy, 0);
        chk("hp_count", hv.size(), 10);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    task automatic check_scen2;
        for (int c = 0; c < 10 && c < hv.size(); c++) begin
            chk("s2_hp_value", hv[c], 32'(40 * (c + 1)));
            chk("s2_hp_class", hc[c], c);
        end
        chk("s2_best_class", best_class, 9);
        chk("s2_best_value", best_value, 400);
    endtask

    initial begin
        int dn;
        fill(1, 0);
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hp_valid", hp_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_x_addr", x_addr, 0);
        chk("rst_th_addr", th_addr, 0);
        chk("rst_hp_value", hp_value, 0);
        chk("rst_best", {best_class, best_value[27:0]}, 0);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("idle_busy", busy, 0);

        fill(1, 0);
        for (int c = 0; c < 10; c++)
            for (int k = 0; k < 41; k++) th_mem[c * 41 + k] = 32'(c + 1);
        run(0);
        check_scen2();

        fill(1, 5);
        run(0);
        for (int c = 0; c < 10 && c < hv.size(); c++) chk("s3_hp_value", hv[c], 200);
        chk("s3_best_class", best_class, 0);
        chk("s3_best_value", best_value, 200);

        fill(1, 0);
        for (int k = 0; k < 41; k++) th_mem[3 * 41 + k] = 32'hFFFF_FFFF;
        run(0);
        if (hv.size() > 3) chk("s4_hp_value3", hv[3], 32'hFFFF_FFD8);
        if (hv.size() > 2) chk("s4_hp_value2", hv[2], 0);
        chk("s4_best_class", best_class, 0);
        chk("s4_best_value", best_value, 0);

        fill(1, 0);
        x_mem[2] = 32'h7FFF_FFFF;
        th_mem[2] = 1;
        th_mem[3] = 1;
        run(0);
`ifdef IPSEQ_SAT_EN
        if (hv.size() > 0) chk("s5_hp_value0", hv[0], 32'h7FFF_FFFF);
        chk("s5_best_class", best_class, 0);
        chk("s5_best_value", best_value, 32'h7FFF_FFFF);
`else
        if (hv.size() > 0) chk("s5_hp_value0", hv[0], 32'h8000_0000);
        chk("s5_best_class", best_class, 1);
        chk("s5_best_value", best_value, 0);
`endif

        fill(1, 0);
        for (int c = 0; c < 10; c++)
            for (int k = 0; k < 41; k++) th_mem[c * 41 + k] = 32'(c + 1);
        run(1);
        check_scen2();

        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        repeat (100) @(negedge clk);
        reset = 1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_hp_value", hp_value, 0);
        chk("abort_best_value", best_value, 0);
        chk("abort_th_addr", th_addr, 0);
        @(negedge clk) reset = 0;
        dn = 0;
        repeat (450) begin
            @(negedge clk);
            if (done || hp_valid) dn++;
        end
        chk("abort_no_done", dn, 0);
        run(0);
        check_scen2();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
